// File: rtl/hsi_pkg.sv
// Shared constants for the gyro HSI transmit path: FSM state codes, default widths, frame length.
// Optional odd-parity bit is enabled by defining HSI_TX_PARITY_EN.
package hsi_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DIV_W_DEF  = 8;

`ifdef HSI_TX_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEAD    = 3'd1;
    localparam logic [2:0] ST_SHIFT_A = 3'd2;
    localparam logic [2:0] ST_SHIFT_B = 3'd3;
    localparam logic [2:0] ST_TRAIL   = 3'd4;

    // Half-periods per frame: lead + two per transmitted bit + trail.
    localparam int unsigned FRAME_HALFPERIODS = 2 * (DATA_W_DEF + PAR_W) + 2;

    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned div_val);
        return (2 * (data_w + PAR_W) + 2) * (div_val + 1);
    endfunction

endpackage

// File: rtl/hsi_tx_halfper_tick.sv
// Loadable half-period down-counter: tick_c pulses when the count hits 0, then reloads the latched divider.
module hsi_tx_halfper_tick
    import hsi_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick_c
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;

    assign o_tick_c = i_en && (r_cnt == '0);

    // Reload from r_div keeps all-ones div at 2^DIV_W cycles without widening.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_cnt <= i_div;
        end else if (i_en) begin
            r_cnt <= o_tick_c ? r_div : r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/hsi_tx_serializer.sv
// Parallel-in, MSB-first serial-out transmitter for the gyro HSI with generated ser_clk and frame strobe.
// Define HSI_TX_PARITY_EN to append an odd-parity bit after the LSB.
module hsi_tx_serializer
    import hsi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              ser_clk,
    output logic              ser_data,
    output logic              ser_frame
);

    localparam int unsigned SHIFT_W = DATA_W + PAR_W;
    localparam int unsigned BIT_W   = $clog2(SHIFT_W + 1);

    logic [2:0]         r_state;
    logic [SHIFT_W-1:0] r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_cpol;

    logic               r_ser_clk;
    logic               r_ser_data;
    logic               r_ser_frame;
    logic               r_done;
    logic               r_in_ready;
    logic               r_busy;

    logic [2:0]         w_state_nxt;
    logic [SHIFT_W-1:0] w_shift_nxt;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic               w_cpol_nxt;
    logic               w_clk_nxt;
    logic               w_data_nxt;
    logic               w_frame_nxt;
    logic               w_done_nxt;
    logic               w_accept;
    logic               w_tick;
    logic [SHIFT_W-1:0] w_load_word;

`ifdef HSI_TX_PARITY_EN
    assign w_load_word = {in_data, ~^in_data};
`else
    assign w_load_word = in_data;
`endif

    assign w_accept = in_valid && (r_state == ST_IDLE);

    hsi_tx_halfper_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_load   (w_accept),
        .i_en     (r_state != ST_IDLE),
        .i_div    (div),
        .o_tick_c (w_tick)
    );

    // Next state, datapath and next registered output values.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_cpol_nxt  = r_cpol;
        w_clk_nxt   = 1'b0;
        w_data_nxt  = 1'b0;
        w_frame_nxt = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_LEAD;
                    w_shift_nxt = w_load_word;
                    w_bit_nxt   = BIT_W'(SHIFT_W);
                    w_cpol_nxt  = cpol;
                end
            end
            ST_LEAD: begin
                if (w_tick) w_state_nxt = ST_SHIFT_A;
            end
            ST_SHIFT_A: begin
                if (w_tick) w_state_nxt = ST_SHIFT_B;
            end
            ST_SHIFT_B: begin
                if (w_tick) begin
                    w_shift_nxt = {r_shift[SHIFT_W-2:0], 1'b0};
                    w_bit_nxt   = r_bit_cnt - BIT_W'(1);
                    w_state_nxt = (r_bit_cnt == BIT_W'(1)) ? ST_TRAIL : ST_SHIFT_A;
                end
            end
            ST_TRAIL: begin
                if (w_tick) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_frame_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt  = (r_state == ST_TRAIL) && w_tick;
        if ((w_state_nxt == ST_SHIFT_A) || (w_state_nxt == ST_SHIFT_B))
            w_data_nxt = w_shift_nxt[SHIFT_W-1];
        if (w_state_nxt == ST_IDLE)
            w_clk_nxt = cpol;
        else if (w_state_nxt == ST_SHIFT_B)
            w_clk_nxt = ~w_cpol_nxt;
        else
            w_clk_nxt = w_cpol_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_cpol    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_cpol    <= w_cpol_nxt;
        end
    end

    // Output registers, so pads see glitch-free levels aligned to state changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ser_clk   <= 1'b0;
            r_ser_data  <= 1'b0;
            r_ser_frame <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_ser_clk   <= w_clk_nxt;
            r_ser_data  <= w_data_nxt;
            r_ser_frame <= w_frame_nxt;
            r_done      <= w_done_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign ser_clk   = r_ser_clk;
    assign ser_data  = r_ser_data;
    assign ser_frame = r_ser_frame;
    assign done      = r_done;
    assign in_ready  = r_in_ready;
    assign busy      = r_busy;

endmodule

// File: tb/tb_hsi_tx_serializer.sv
// Self-checking bench for hsi_tx_serializer: directed and random frames against a waveform/receiver model.
module tb_hsi_tx_serializer;
    import hsi_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned VW = 8;
    localparam int unsigned SW = DW + PAR_W;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic [VW-1:0] div      = '0;
    logic          cpol     = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready, busy, done, ser_clk, ser_data, ser_frame;

    int checks   = 0;
    int failures = 0;

    hsi_tx_serializer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .div       (div),
        .cpol      (cpol),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .ser_clk   (ser_clk),
        .ser_data  (ser_data),
        .ser_frame (ser_frame)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bits on the wire, MSB first, with the odd-parity bit appended when enabled.
    function automatic logic [SW-1:0] tx_word(input logic [DW-1:0] d);
`ifdef HSI_TX_PARITY_EN
        return {d, 1'(($countones(d) % 2) == 0)};
`else
        return d;
`endif
    endfunction

    task automatic accept(input logic [DW-1:0] data, input logic [VW-1:0] d, input logic c,
                          input bit hold, input logic [DW-1:0] next_data);
        int n = 0;
        @(negedge clock);
        in_valid = 1'b1; in_data = data; div = d; cpol = c;
        while (in_ready !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) chk("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
        if (hold) begin
            in_data = next_data;
        end else begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            div      = VW'($urandom);
            cpol     = ~c;
        end
    endtask

    task automatic check_frame(input logic [DW-1:0] data, input logic [VW-1:0] d, input logic c,
                               input bit drop_valid);
        logic [SW-1:0] w     = tx_word(data);
        int            hp    = int'(d) + 1;
        int            n     = (2 * SW + 2) * hp;
        int            errs  = 0;
        int            nhigh = 0;
        int            nrx   = 0;
        logic [SW-1:0] rx    = '0;
        logic          prev  = c;
        logic          ec, ed;
        for (int k = 0; k < n; k++) begin
            int h;
            int j;
            @(negedge clock);
            if (k == 0 && drop_valid) in_valid = 1'b0;
            h = k / hp;
            if (h == 0 || h == 2 * SW + 1) begin
                ec = c; ed = 1'b0;
            end else begin
                j  = h - 1;
                ec = (j % 2 == 1) ? ~c : c;
                ed = w[SW - 1 - j / 2];
            end
            if (ser_frame === 1'b1) nhigh++;
            if (ser_frame !== 1'b1 || ser_clk !== ec || ser_data !== ed ||
                busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) errs++;
            if (prev == c && ser_clk !== c) begin
                rx = {rx[SW-2:0], ser_data};
                nrx++;
            end
            prev = ser_clk;
        end
        chk("waveform_errs", errs, 0);
        chk("frame_len", nhigh, n);
        chk("rx_word", 32'(rx), 32'(w));
        chk("rx_bits", nrx, SW);
        @(negedge clock);
        chk("done_pulse", 32'(done), 1);
        chk("frame_low", 32'(ser_frame), 0);
        chk("ready_after", 32'(in_ready), 1);
        chk("idle_clk", 32'(ser_clk), 32'(cpol));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_frame", 32'(ser_frame), 0);
        chk("rst_clk", 32'(ser_clk), 0);
        chk("rst_data", 32'(ser_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_out_of_rst", 32'(in_ready), 1);

        accept(16'hA5C3, 8'd0, 1'b0, 1'b0, '0);
        check_frame(16'hA5C3, 8'd0, 1'b0, 1'b0);

        accept(16'h8001, 8'd3, 1'b0, 1'b0, '0);
        check_frame(16'h8001, 8'd3, 1'b0, 1'b0);

        @(negedge clock);
        cpol = 1'b1;
        @(negedge clock);
        chk("idle_cpol1", 32'(ser_clk), 1);
        accept(16'h00FF, 8'd1, 1'b1, 1'b0, '0);
        check_frame(16'h00FF, 8'd1, 1'b1, 1'b0);

        accept(16'h1234, 8'd2, 1'b0, 1'b1, 16'hBEEF);
        check_frame(16'h1234, 8'd2, 1'b0, 1'b0);
        check_frame(16'hBEEF, 8'd2, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] rd = DW'($urandom);
            logic [VW-1:0] rv = VW'($urandom_range(0, 5));
            logic          rc = 1'($urandom_range(0, 1));
            accept(rd, rv, rc, 1'b0, '0);
            check_frame(rd, rv, rc, 1'b0);
        end

        begin
            logic [DW-1:0] rd = DW'($urandom);
            accept(rd, 8'hFF, 1'b0, 1'b0, '0);
            check_frame(rd, 8'hFF, 1'b0, 1'b0);
        end

        accept(16'h0001, 8'd0, 1'b0, 1'b0, '0);
        check_frame(16'h0001, 8'd0, 1'b0, 1'b0);
        accept(16'h0000, 8'd0, 1'b0, 1'b0, '0);
        check_frame(16'h0000, 8'd0, 1'b0, 1'b0);

        begin
            int   edges = 0;
            int   n     = 0;
            logic prev  = 1'b0;
            int   dones = 0;
            accept(16'hC3A5, 8'd1, 1'b0, 1'b0, '0);
            cpol = 1'b0;
            while (edges < 5 && n < 1000) begin
                @(negedge clock);
                if (prev == 1'b0 && ser_clk === 1'b1) edges++;
                prev = ser_clk;
                n++;
            end
            if (n >= 1000) chk("sample_edge_timeout", 0, 1);
            #2;
            reset_n = 1'b0;
            #1;
            chk("midrst_frame", 32'(ser_frame), 0);
            chk("midrst_clk", 32'(ser_clk), 0);
            chk("midrst_data", 32'(ser_data), 0);
            chk("midrst_busy", 32'(busy), 0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clock);
                if (done === 1'b1) dones++;
            end
            reset_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clock);
                if (done === 1'b1) dones++;
            end
            chk("midrst_no_done", dones, 0);
            chk("midrst_ready", 32'(in_ready), 1);
        end

        accept(16'h5A5A, 8'd0, 1'b0, 1'b0, '0);
        check_frame(16'h5A5A, 8'd0, 1'b0, 1'b0);
        @(negedge clock);
        chk("done_one_cycle", 32'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
